// File: rtl/sound_latch_ctrl_if.sv
// sound_latch_ctrl_if: 68000 write strobe, Z80 port selects, IRQ handshake and latch outputs of the sound latch.
interface sound_latch_ctrl_if;
  logic       z80_cen;
  logic       sound_latch_cs;
  logic       m68k_rw;
  logic       m68k_lds_n;
  logic [7:0] m68k_din;
  logic       z80_latch_r_cs;
  logic       z80_latch_clr_cs;
  logic       z80_rd_n;
  logic       M1_n;
  logic       IORQ_n;
  logic [7:0] latch_dout;
  logic       latch_pending;
  logic       latch_overrun;
  logic       z80_irq_n;
  modport master (
    output z80_cen, sound_latch_cs, m68k_rw, m68k_lds_n, m68k_din,
           z80_latch_r_cs, z80_latch_clr_cs, z80_rd_n, M1_n, IORQ_n,
    input  latch_dout, latch_pending, latch_overrun, z80_irq_n
  );
  modport slave (
    input  z80_cen, sound_latch_cs, m68k_rw, m68k_lds_n, m68k_din,
           z80_latch_r_cs, z80_latch_clr_cs, z80_rd_n, M1_n, IORQ_n,
    output latch_dout, latch_pending, latch_overrun, z80_irq_n
  );
endinterface

// File: rtl/sound_latch_ctrl.sv
// sound_latch_ctrl: 68000-to-Z80 sound command latch with periodic Z80 IRQ held until acknowledge.
module sound_latch_ctrl #(
  parameter int IRQ_PERIOD = 32768,
  parameter int CW         = 16
) (
  input logic               clk_sys,
  input logic               reset_n,
  sound_latch_ctrl_if.slave bus
);
  typedef enum logic {IDLE, ASSERT} irq_st_t;
  localparam logic [CW-1:0] LAST = CW'(IRQ_PERIOD - 1);
  logic          wr_req, wr_req_q, clr_q, wr_pulse, clr_pulse, irq_set, irq_ack;
  logic [7:0]    latch_q, latch_d;
  logic          pend_q, pend_d, ovr_q, ovr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  irq_st_t       st_q;
  logic          unused_rd;
  assign unused_rd = bus.z80_latch_r_cs & bus.z80_rd_n;
  assign wr_req    = bus.sound_latch_cs & ~bus.m68k_rw & ~bus.m68k_lds_n;
  assign wr_pulse  = wr_req & ~wr_req_q;
  assign clr_pulse = bus.z80_latch_clr_cs & ~clr_q;
  assign irq_set   = bus.z80_cen && cnt_q == LAST;
  assign irq_ack   = ~bus.M1_n & ~bus.IORQ_n;
  // a colliding write keeps the data but still clears the overrun flag
  always_comb begin
    latch_d = wr_pulse ? bus.m68k_din : clr_pulse ? 8'h00 : latch_q;
    pend_d  = wr_pulse | (pend_q & ~clr_pulse);
    ovr_d   = clr_pulse ? 1'b0 : ovr_q | (wr_pulse & pend_q);
    cnt_d   = !bus.z80_cen ? cnt_q : irq_set ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_req_q <= 1'b0;
      clr_q    <= 1'b0;
      latch_q  <= 8'h00;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
      st_q     <= IDLE;
    end else begin
      wr_req_q <= wr_req;
      clr_q    <= bus.z80_latch_clr_cs;
      latch_q  <= latch_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
      st_q     <= irq_set ? ASSERT : irq_ack ? IDLE : st_q;
    end
  end
  assign bus.latch_dout    = latch_q;
  assign bus.latch_pending = pend_q;
  assign bus.latch_overrun = ovr_q;
  assign bus.z80_irq_n     = st_q != ASSERT;
endmodule

// File: doc/sound_latch_ctrl.md
# sound_latch_ctrl

Responder side of the 68000-to-Z80 sound command path. It consumes the `sound_latch_cs`, `z80_latch_r_cs` and `z80_latch_clr_cs` selects produced by the address decoder. The block holds the byte written by the 68000 and presents it to the Z80 on the port 0x06 read. It clears the byte on a Z80 port 0x04 access. It also generates the Z80 periodic IRQ with hold-until-acknowledge semantics.

## Interface
Parameters:
- `IRQ_PERIOD`, default 32768: number of `z80_cen` ticks between Z80 IRQ assertions (6 MHz / 32768 ≈ 183 Hz).
- `CW`, default 16: width of the IRQ period counter; must satisfy 2^CW ≥ IRQ_PERIOD.

Ports:
- `clk_sys`  in  1  system clock; all logic runs on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `z80_cen`  in  1  Z80 clock enable, one `clk_sys` pulse per Z80 T-state.
- `sound_latch_cs`  in  1  68000 sound latch select; already qualified with AS.
- `m68k_rw`  in  1  68000 R/W: 1 = read, 0 = write.
- `m68k_lds_n`  in  1  68000 lower data strobe, active low.
- `m68k_din`  in  8  68000 data bus bits [7:0].
- `z80_latch_r_cs`  in  1  Z80 I/O read select for port 0x06.
- `z80_latch_clr_cs`  in  1  Z80 I/O select for port 0x04.
- `z80_rd_n`  in  1  Z80 RD, active low.
- `M1_n`  in  1  Z80 M1, active low.
- `IORQ_n`  in  1  Z80 IORQ, active low.
- `latch_dout`  out  8  latch contents, driven onto the Z80 data bus when `z80_latch_r_cs` and `!z80_rd_n` are both true.
- `latch_pending`  out  1  a command has been written and not yet cleared.
- `latch_overrun`  out  1  sticky: the 68000 wrote while a command was still pending.
- `z80_irq_n`  out  1  Z80 INT, active low.

## Operation
Write strobe:
- `wr_req = sound_latch_cs & !m68k_rw & !m68k_lds_n`.
- A registered copy `wr_req_d` provides rising-edge detection: `wr_pulse = wr_req & !wr_req_d`.
- Exactly one capture happens per 68000 bus cycle, however many clocks the strobe is held.

Write action, on `wr_pulse`:
- `latch <= m68k_din`.
- `latch_pending <= 1`.
- If `latch_pending` was already 1, then `latch_overrun <= 1`.

Clear strobe:
- `clr_pulse` is the rising edge of `z80_latch_clr_cs`, detected the same way as the write strobe.
- It responds to any access to port 0x04, read or write.

Clear action, on `clr_pulse`:
- `latch <= 0`, `latch_pending <= 0`, `latch_overrun <= 0`.

Simultaneous `wr_pulse` and `clr_pulse`:
- The write wins: `latch` takes the new data and `latch_pending = 1`.
- `latch_overrun` is cleared.

Read:
- `latch_dout = latch`, registered, with no side effects.
- A Z80 read never clears the latch or the pending flag.

IRQ timer:
- `irq_cnt` increments on each `z80_cen`.
- When `z80_cen` arrives with `irq_cnt == IRQ_PERIOD-1`, `irq_cnt` wraps to 0 and `irq_set` fires.
- The counter free-runs and is unaffected by IRQ acknowledge.

IRQ state machine, two states:
- IDLE (`z80_irq_n = 1`) → ASSERT on `irq_set`.
- ASSERT (`z80_irq_n = 0`) → IDLE on `irq_ack`, where `irq_ack = !M1_n & !IORQ_n` sampled on `clk_sys`.
- `irq_set` while in ASSERT: stay in ASSERT. Missed periods are not queued.
- `irq_set` and `irq_ack` in the same cycle: `irq_set` wins and the state remains ASSERT.

## Timing
Reset values (asynchronous, on `reset_n = 0`):
- `latch` = 0x00, `latch_dout` = 0x00.
- `latch_pending` = 0, `latch_overrun` = 0.
- `z80_irq_n` = 1, `irq_cnt` = 0.
- `wr_req_d` = 0, clear-edge register = 0.

Latencies:
- `latch_dout`, `latch_pending` and `latch_overrun` update on the `clk_sys` edge that samples `wr_pulse` or `clr_pulse`, and are visible in the following cycle.
- `z80_irq_n` falls on the edge at which `irq_set` is sampled.
- `z80_irq_n` rises on the first edge at which `irq_ack` is sampled high.
- First IRQ assertion: after exactly `IRQ_PERIOD` `z80_cen` ticks following reset release.

Reset mid-operation:
- All state returns immediately to the reset values.
- A strobe still held high when reset releases is detected as a new edge and captured.

Width rules:
- `irq_cnt` is CW bits wide and compared against `IRQ_PERIOD-1` truncated to CW bits.
- No arithmetic on the latch value.

## Test plan
1. **Single write:** reset, then a 68000 write of 0x5A held for 4 clocks → `latch_dout` = 0x5A one clock after the strobe rises; `latch_pending` = 1; exactly one capture (a spy counter reads 1).
2. **Overrun and clear:** write 0x11, then write 0x22 → `latch_dout` = 0x22, `latch_overrun` = 1. Then pulse `z80_latch_clr_cs` → `latch_dout` = 0x00, `latch_pending` = 0, `latch_overrun` = 0.
3. **Write/clear collision:** `wr_pulse` and `clr_pulse` in the same cycle with data 0x7E → `latch_dout` = 0x7E, `latch_pending` = 1, `latch_overrun` = 0.
4. **Read has no side effects:** Z80 reads port 0x06 three times after a write of 0xA3 → `latch_dout` = 0xA3 each time and `latch_pending` stays 1.
5. **IRQ period and acknowledge:** `IRQ_PERIOD` = 8, `z80_cen` every clock → `z80_irq_n` falls 8 clocks after reset release and stays low until `M1_n = 0` and `IORQ_n = 0`, then rises the next cycle. The next fall occurs 8 ticks after the previous fall, independent of ack timing.
6. **Unacknowledged IRQ and reset:** no acknowledge for 3 periods → `z80_irq_n` stays low with a single pending request. Asserting `reset_n = 0` mid-period → `z80_irq_n` = 1 and `irq_cnt` = 0 immediately, without waiting for a clock.
